// File: rtl/hazard_stall_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : hazard_stall_unit                                             |
// | Purpose  : Stall/flush controller for the 5-stage pipeline. Handles the  |
// |            hazards forwarding cannot cover: load-use, data-memory wait,  |
// |            multi-cycle multiply and taken-branch flush. Drives per-stage |
// |            register write enables and bubble controls, and counts stall  |
// |            cycles (saturating) for performance monitoring.               |
// | Ports    : clk, rst_n (async, active-low)                                |
// |            hazard inputs : IdExMemRead_i, IdExRegisterRt_i,              |
// |                            IfIdRegisterRs_i, IfIdRegisterRt_i,           |
// |                            IfIdUsesRt_i, branchTaken_i, mulStart_i,      |
// |                            dmemReq_i, dmemReady_i                        |
// |            enables       : pcWrite_o, ifIdWrite_o, idExWrite_o,          |
// |                            exMemWrite_o, memWbWrite_o                    |
// |            bubbles/flush : ifIdFlush_o, idExBubble_o, exMemBubble_o,     |
// |                            memWbBubble_o                                 |
// |            status        : busy_o, stallCount_o[15:0]                    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module hazard_stall_unit #(
  parameter int MUL_LATENCY = 4   // EX cycles of the multiplier, 1..16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        IdExMemRead_i,
  input  logic [4:0]  IdExRegisterRt_i,
  input  logic [4:0]  IfIdRegisterRs_i,
  input  logic [4:0]  IfIdRegisterRt_i,
  input  logic        IfIdUsesRt_i,
  input  logic        branchTaken_i,
  input  logic        mulStart_i,
  input  logic        dmemReq_i,
  input  logic        dmemReady_i,
  output logic        pcWrite_o,
  output logic        ifIdWrite_o,
  output logic        idExWrite_o,
  output logic        exMemWrite_o,
  output logic        memWbWrite_o,
  output logic        ifIdFlush_o,
  output logic        idExBubble_o,
  output logic        exMemBubble_o,
  output logic        memWbBubble_o,
  output logic        busy_o,
  output logic [15:0] stallCount_o
);

  // A single-cycle multiplier needs no hold at all.
  localparam bit          MUL_EN       = (MUL_LATENCY > 1);
  // The RUN cycle that starts the multiply is the first stall cycle, so the
  // wait counter only has to cover the remaining MUL_LATENCY-2 cycles.
  localparam int          MUL_LOAD_INT = (MUL_LATENCY > 1) ? (MUL_LATENCY - 2) : 0;
  localparam logic [3:0]  MUL_LOAD     = MUL_LOAD_INT[3:0];

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MUL_WAIT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] stallCount_q;

  logic loadUse;
  logic freeze;     // full freeze while data memory is not ready
  logic mulHold;    // hold IF/ID/EX while the multiplier occupies EX
  logic lowRules;   // load-use / branch evaluation is allowed this cycle

  assign loadUse = IdExMemRead_i && (IdExRegisterRt_i != 5'd0) &&
                   ((IdExRegisterRt_i == IfIdRegisterRs_i) ||
                    (IfIdUsesRt_i && (IdExRegisterRt_i == IfIdRegisterRt_i)));

  // Next-state and control outputs
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    freeze        = 1'b0;
    mulHold       = 1'b0;
    lowRules      = 1'b0;

    pcWrite_o     = 1'b1;
    ifIdWrite_o   = 1'b1;
    idExWrite_o   = 1'b1;
    exMemWrite_o  = 1'b1;
    memWbWrite_o  = 1'b1;
    ifIdFlush_o   = 1'b0;
    idExBubble_o  = 1'b0;
    exMemBubble_o = 1'b0;
    memWbBubble_o = 1'b0;

    unique case (state_q)
      RUN: begin
        if (dmemReq_i && !dmemReady_i) begin
          freeze  = 1'b1;
          state_d = MEM_WAIT;
        end else if (mulStart_i && MUL_EN) begin
          mulHold = 1'b1;
          cnt_d   = MUL_LOAD;
          state_d = MUL_WAIT;
        end else begin
          lowRules = 1'b1;
        end
      end
      MEM_WAIT: begin
        // Anything deferred by the freeze is re-evaluated on the ready cycle.
        if (!dmemReady_i) begin
          freeze = 1'b1;
        end else if (mulStart_i && MUL_EN) begin
          mulHold = 1'b1;
          cnt_d   = MUL_LOAD;
          state_d = MUL_WAIT;
        end else begin
          lowRules = 1'b1;
          state_d  = RUN;
        end
      end
      MUL_WAIT: begin
        // MEM only carries bubbles here, so dmemReq is irrelevant; on the
        // release cycle mulStart still reflects the finishing multiply.
        if (cnt_q != 4'd0) begin
          mulHold = 1'b1;
          cnt_d   = cnt_q - 4'd1;
        end else begin
          lowRules = 1'b1;
          state_d  = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (freeze) begin
      pcWrite_o     = 1'b0;
      ifIdWrite_o   = 1'b0;
      idExWrite_o   = 1'b0;
      exMemWrite_o  = 1'b0;
      memWbBubble_o = 1'b1;
    end
    if (mulHold) begin
      pcWrite_o     = 1'b0;
      ifIdWrite_o   = 1'b0;
      idExWrite_o   = 1'b0;
      exMemBubble_o = 1'b1;
    end
    if (lowRules) begin
      // Load-use wins over the branch flush.
      if (loadUse) begin
        pcWrite_o    = 1'b0;
        ifIdWrite_o  = 1'b0;
        idExBubble_o = 1'b1;
      end else if (branchTaken_i) begin
        ifIdFlush_o  = 1'b1;
        idExBubble_o = 1'b1;
      end
    end

    // Reset overrides everything asynchronously: hold all stages, bubble all.
    if (!rst_n) begin
      pcWrite_o     = 1'b0;
      ifIdWrite_o   = 1'b0;
      idExWrite_o   = 1'b0;
      exMemWrite_o  = 1'b0;
      memWbWrite_o  = 1'b0;
      ifIdFlush_o   = 1'b0;
      idExBubble_o  = 1'b1;
      exMemBubble_o = 1'b1;
      memWbBubble_o = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      cnt_q        <= 4'd0;
      stallCount_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!pcWrite_o && (stallCount_q != 16'hFFFF)) begin
        stallCount_q <= stallCount_q + 16'd1;
      end
    end
  end

  assign busy_o       = rst_n && (state_q != RUN);
  assign stallCount_o = stallCount_q;

endmodule
`default_nettype wire

// File: doc/hazard_stall_unit.md
# hazard_stall_unit

Pipeline stall and flush controller for the 5-stage core: the counterpart to the forwarding logic, covering the hazards forwarding cannot resolve. Detects load-use hazards, freezes the pipe while data memory is not ready, holds upstream stages for a multi-cycle multiply, and flushes IF/ID on a taken branch. It drives the per-stage register write enables and bubble controls, and keeps a saturating stall-cycle counter for performance monitoring.

## Interface
- MUL_LATENCY, default 4: EX cycles of the multiplier, legal range 1..16.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- IdExMemRead  in  1  instruction in EX is a load.
- IdExRegisterRt  in  5  load destination register.
- IfIdRegisterRs  in  5  source register of the instruction in ID.
- IfIdRegisterRt  in  5  second source register of the instruction in ID.
- IfIdUsesRt  in  1  the instruction in ID reads Rt.
- branchTaken  in  1  branch resolved taken in EX.
- mulStart  in  1  a multiply occupies EX; held while it stays there.
- dmemReq  in  1  MEM-stage instruction accesses data memory.
- dmemReady  in  1  data memory completes the access this cycle.
- pcWrite, ifIdWrite, idExWrite, exMemWrite, memWbWrite  out  1 each  stage register write enables.
- ifIdFlush  out  1  load a NOP into IF/ID.
- idExBubble, exMemBubble, memWbBubble  out  1 each  zero the control fields written into that register.
- busy  out  1  state is not RUN.
- stallCount  out  16  cycles with pcWrite=0 since reset; saturating.

## Operation
- loadUse = IdExMemRead & (IdExRegisterRt != 0) & ((IdExRegisterRt == IfIdRegisterRs) | (IfIdUsesRt & (IdExRegisterRt == IfIdRegisterRt))).
- Default outputs: all Write=1, all Bubble=0, ifIdFlush=0.
- FSM states: RUN, MEM_WAIT, MUL_WAIT. A 4-bit counter cnt is used in MUL_WAIT.
- RUN: rules are evaluated in priority order and the first match applies.
  1. dmemReq & !dmemReady: freeze. pcWrite, ifIdWrite, idExWrite and exMemWrite are 0; memWbBubble=1. Next state MEM_WAIT.
  2. mulStart & MUL_LATENCY>1: pcWrite, ifIdWrite and idExWrite are 0; exMemBubble=1. Load cnt=MUL_LATENCY-2. Next state MUL_WAIT.
  3. loadUse: pcWrite=0, ifIdWrite=0, idExBubble=1.
  4. branchTaken: ifIdFlush=1, idExBubble=1.
- MEM_WAIT:
  - While !dmemReady: freeze exactly as in RUN rule 1.
  - On the cycle dmemReady=1: evaluate RUN rules 2-4, then go to RUN, or to MUL_WAIT if rule 2 fired.
- MUL_WAIT:
  - While cnt!=0: same outputs as RUN rule 2; cnt decrements.
  - On the cycle cnt==0 (release): mulStart is ignored, RUN rules 3-4 are evaluated, and the next state is RUN.
  - dmemReq is ignored in this state, because MEM holds only bubbles.
- MUL_LATENCY=1: mulStart is ignored entirely.
- stallCount increments on every clock edge where pcWrite=0 and rst_n=1. It holds at 16'hFFFF once reached.

## Timing
- While rst_n=0 (asynchronous):
  - State forced to RUN, cnt=0, stallCount=0.
  - All Write outputs 0, all Bubble outputs 1, ifIdFlush=0, busy=0.
- Reset asserted mid-stall aborts the stall with no residual state.
- All control outputs are combinational from state and inputs in the same cycle. No output latency.
- Load-use costs exactly 1 stall cycle; no state is involved, because the inserted bubble removes the hazard on the next cycle.
- A multiply stalls the upstream stages for MUL_LATENCY-1 consecutive cycles. The release cycle follows with pcWrite=1, unless a lower-priority rule fires in that cycle.
- A memory freeze lasts N cycles for N cycles of !dmemReady. The ready cycle is not a stall, unless rule 2 or 3 fires.
- Simultaneous events:
  - The memory freeze dominates a multiply, load-use or branch in the same cycle; those are re-evaluated on the ready cycle.
  - A branch flush and a load-use stall never both apply; load-use wins.
- busy is high in MEM_WAIT and in MUL_WAIT, including the release cycle.

## Test plan
- **Load-use:** IdExMemRead=1, IdExRegisterRt=5, IfIdRegisterRs=5 for one cycle -> pcWrite=0, ifIdWrite=0, idExBubble=1 for 1 cycle; stallCount=1. Repeat with Rt=0 -> no stall.
- **Multiply:** MUL_LATENCY=4, mulStart held 4 cycles -> pcWrite=0 and exMemBubble=1 for cycles 1-3, pcWrite=1 on cycle 4; busy high on cycles 2-4 (state MUL_WAIT); stallCount=3.
- **Memory wait:** dmemReq=1, dmemReady low for 3 cycles then high -> full freeze (exMemWrite=0, memWbBubble=1) for 3 cycles; all Write=1 on the ready cycle; stallCount=3.
- **Freeze priority:** memory wait coinciding with mulStart and branchTaken -> freeze only; on the ready cycle the multiply stall starts and the branch flush is deferred to the multiply release cycle.
- **Branch:** branchTaken=1 with no other hazard -> ifIdFlush=1, idExBubble=1, pcWrite=1.
- **Reset:** rst_n pulsed low during MUL_WAIT with cnt=2 -> outputs go to reset values immediately, and after release the next mulStart restarts the full 3-cycle stall.
- **Saturation:** force 70000 stall cycles -> stallCount holds at 16'hFFFF.
